// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling from an internal clocks-per-bit counter.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra rx_parity_err pulse output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF) begin
          // A high line at mid start bit is a glitch, not a frame.
          state_d   = rx_s_q ? IDLE : DATA;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL) begin
          shift_d[bit_idx_q] = rx_s_q;
          clk_cnt_d          = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == FULL) begin
          par_d     = rx_s_q;
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == FULL) begin
          clk_cnt_d = '0;
          // Leaving at mid-stop lets a start edge right after the stop bit be caught.
          if (rx_s_q) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus glitch/reset/parity sequences.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int applied = 0;
  int fails   = 0;
  int vcnt    = 0;
  int fcnt    = 0;
  int pcnt    = 0;

  // Pulse counters; valid and frame error must never coincide.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vcnt++;
      if (rx_frame_err) fcnt++;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) pcnt++;
`endif
      if (rx_valid && rx_frame_err) begin
        fails++;
        $display("FAIL overlap: rx_valid and rx_frame_err both 1 at %0t", $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         pre_idle;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, f0, p0;
    vecs[0] = '{8'hA5, 1'b1, 0,  32, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  16, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,   0, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 48,  0, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 0,  16, 1, 0, 8'h81};
    vecs[5] = '{8'h01, 1'b1, 0,  16, 1, 0, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 0,   0, 1, 0, 8'h80};
    vecs[7] = '{8'h5A, 1'b1, 0,   5, 1, 0, 8'h5A};

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_data", {24'h0, rx_data}, 32'h0);
    check("reset rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset rx_frame_err", {31'h0, rx_frame_err}, 32'h0);
    check("reset rx_busy", {31'h0, rx_busy}, 32'h0);
    rst_n = 1'b1;
    idle(8);

    for (int i = 0; i < 8; i++) begin
      idle(vecs[i].pre_idle);
      v0 = vcnt;
      f0 = fcnt;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      if (vecs[i].hold_low > 0) begin
        rx_in = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clk);
      end
      #1;
      check($sformatf("vec%0d valid pulses", i), vcnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d frame_err pulses", i), fcnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d rx_data", i), {24'h0, rx_data}, {24'h0, vecs[i].exp_data});
      check($sformatf("vec%0d rx_busy", i), {31'h0, rx_busy}, (vecs[i].hold_low > 0) ? 32'h1 : 32'h0);
    end

    // Short low glitch on an idle line: START aborts, no pulses, data kept.
    idle(32);
    v0 = vcnt;
    f0 = fcnt;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy during", {31'h0, rx_busy}, 32'h1);
    idle(24);
    check("glitch busy after", {31'h0, rx_busy}, 32'h0);
    check("glitch valid pulses", vcnt - v0, 32'h0);
    check("glitch frame_err pulses", fcnt - f0, 32'h0);
    check("glitch rx_data", {24'h0, rx_data}, 32'h5A);

    // Reset during data bit 4 of 0x55, then a clean 0x99 frame.
    v0 = vcnt;
    f0 = fcnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("pre-reset busy", {31'h0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-reset busy", {31'h0, rx_busy}, 32'h0);
    check("mid-reset rx_data", {24'h0, rx_data}, 32'h0);
    rst_n = 1'b1;
    idle(32);
    check("aborted frame valid", vcnt - v0, 32'h0);
    check("aborted frame frame_err", fcnt - f0, 32'h0);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(4);
    check("post-reset valid pulses", vcnt - v0, 32'h1);
    check("post-reset rx_data", {24'h0, rx_data}, 32'h99);

`ifdef UART_RX_PARITY_EN
    idle(16);
    v0 = vcnt;
    p0 = pcnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("parity ok valid", vcnt - v0, 32'h1);
    check("parity ok perr", pcnt - p0, 32'h0);
    check("parity ok rx_data", {24'h0, rx_data}, 32'h07);
    idle(16);
    send_frame(8'h5A, 1'b1, 1'b0);
    v0 = vcnt;
    p0 = pcnt;
    idle(16);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("parity bad valid", vcnt - v0, 32'h0);
    check("parity bad perr", pcnt - p0, 32'h1);
    check("parity bad rx_data", {24'h0, rx_data}, 32'h5A);
    v0 = vcnt;
    p0 = pcnt;
    f0 = fcnt;
    idle(16);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(CPB);
    check("frame+parity ferr", fcnt - f0, 32'h1);
    check("frame+parity perr", pcnt - p0, 32'h0);
`else
    p0 = pcnt;
    check("no parity pulses", pcnt - p0, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end
endmodule
